// File: rtl/max_tree_pkg.sv
// Shared helpers for the max_tree_pipe comparator tree.
// Optional feature macro: MAX_TREE_APPROX_EN (coarse compare ignoring APPROX_LSB low bits).
package max_tree_pkg;

`ifdef MAX_TREE_APPROX_EN
  localparam bit APPROX_ON = 1'b1;
`else
  localparam bit APPROX_ON = 1'b0;
`endif

  // Operands are zero-extended to this width before comparing; W must not exceed it.
  localparam int CMP_MAX_W = 64;

  // Number of registered tree levels for n leaves.
  function automatic int tree_levels(input int n);
    return $clog2(n);
  endfunction

  // Leaf count after padding n up to a power of two.
  function automatic int tree_pad(input int n);
    return 1 << $clog2(n);
  endfunction

  // Depth of heap-numbered node i (root = 1 at depth 0).
  function automatic int node_depth(input int i);
    return $clog2(i + 1) - 1;
  endfunction

  // Effective number of ignored LSBs; zero unless the coarse compare is built in.
  function automatic int cmp_lsb(input int lsb);
    return APPROX_ON ? lsb : 0;
  endfunction

  // Strict unsigned greater-than on the compared bit range.
  function automatic logic val_gt(input logic [CMP_MAX_W-1:0] a,
                                  input logic [CMP_MAX_W-1:0] b,
                                  input int lsb);
    return (a >> lsb) > (b >> lsb);
  endfunction

endpackage

// File: rtl/max_tree_cmp2.sv
// One registered 2-input compare-select node. Operand a always carries the lower
// channel indices, so ties resolve to a.
// Optional feature macro: MAX_TREE_APPROX_EN (via max_tree_pkg::cmp_lsb).
module max_tree_cmp2
  import max_tree_pkg::*;
#(
  parameter int W          = 8,
  parameter int IW         = 2,
  parameter int APPROX_LSB = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [W-1:0]  a_val,
  input  logic [IW-1:0] a_idx,
  input  logic [W-1:0]  b_val,
  input  logic [IW-1:0] b_idx,
  output logic [W-1:0]  q_val,
  output logic [IW-1:0] q_idx
);

  logic b_win;

  assign b_win = val_gt(CMP_MAX_W'(b_val), CMP_MAX_W'(a_val), cmp_lsb(APPROX_LSB));

  // Capture the winner only when the upstream stage holds a valid beat and the pipe advances.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_val <= '0;
      q_idx <= '0;
    end else if (en) begin
      q_val <= b_win ? b_val : a_val;
      q_idx <= b_win ? b_idx : a_idx;
    end
  end

endmodule

// File: rtl/max_tree_pipe.sv
// Streaming N-channel max finder: pipelined comparator tree per beat plus a frame
// accumulator that reports the running max (value, channel, first beat) at in_last.
// Optional feature macro: MAX_TREE_APPROX_EN (compare ignores APPROX_LSB low bits).
module max_tree_pipe
  import max_tree_pkg::*;
#(
  parameter  int N          = 4,
  parameter  int W          = 8,
  parameter  int CW         = 8,
  parameter  int APPROX_LSB = 2,
  localparam int IW         = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*W-1:0] in_data,
  input  logic           in_last,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_max,
  output logic [IW-1:0]  out_idx,
  output logic           out_last,
  output logic           frame_valid,
  output logic [W-1:0]   frame_max,
  output logic [IW-1:0]  frame_idx,
  output logic [CW-1:0]  frame_beat
);

  localparam int S = tree_levels(N);
  localparam int P = tree_pad(N);

  typedef struct packed {
    logic [W-1:0]  val;
    logic [IW-1:0] idx;
    logic [CW-1:0] beat;
  } acc_t;

  logic          adv;
  logic [S:1]    v_q;
  logic [S:1]    last_q;
  logic [W-1:0]  lf_val [0:P-1];
  logic [IW-1:0] lf_idx [0:P-1];
  logic [W-1:0]  nd_val [1:P-1];
  logic [IW-1:0] nd_idx [1:P-1];

  logic          xfer;
  logic          take;
  acc_t          acc;
  acc_t          acc_next;
  acc_t          frame_res;
  logic [CW-1:0] beat_cnt;

  // Whole pipe stalls together when the result register is full and not drained.
  assign in_ready = ~out_valid | out_ready;
  assign adv      = in_ready;

  // Leaves: real channels, then zero-valued pads at indices >= N that can only tie.
  for (genvar c = 0; c < P; c++) begin : g_leaf
    if (c < N) begin : g_real
      assign lf_val[c] = in_data[c*W +: W];
    end else begin : g_pad
      assign lf_val[c] = '0;
    end
    assign lf_idx[c] = IW'(c);
  end

  // Heap-numbered tree: node i compares children 2i (lower indices) and 2i+1.
  for (genvar i = 1; i < P; i++) begin : g_node
    localparam int ST = S - node_depth(i);
    logic          en;
    logic [W-1:0]  a_v, b_v;
    logic [IW-1:0] a_i, b_i;

    if (2*i >= P) begin : g_from_leaf
      assign a_v = lf_val[2*i-P];
      assign a_i = lf_idx[2*i-P];
      assign b_v = lf_val[2*i+1-P];
      assign b_i = lf_idx[2*i+1-P];
    end else begin : g_from_node
      assign a_v = nd_val[2*i];
      assign a_i = nd_idx[2*i];
      assign b_v = nd_val[2*i+1];
      assign b_i = nd_idx[2*i+1];
    end

    if (ST == 1) begin : g_en_in
      assign en = adv & in_valid;
    end else begin : g_en_stage
      assign en = adv & v_q[ST-1];
    end

    max_tree_cmp2 #(.W(W), .IW(IW), .APPROX_LSB(APPROX_LSB)) u_cmp (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .a_val (a_v),
      .a_idx (a_i),
      .b_val (b_v),
      .b_idx (b_i),
      .q_val (nd_val[i]),
      .q_idx (nd_idx[i])
    );
  end

  // Stage valid and last flags shift alongside the tree levels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q    <= '0;
      last_q <= '0;
    end else if (adv) begin
      v_q[1]    <= in_valid;
      last_q[1] <= in_valid & in_last;
      for (int s = 2; s <= S; s++) begin
        v_q[s]    <= v_q[s-1];
        last_q[s] <= last_q[s-1];
      end
    end
  end

  assign out_valid = v_q[S];
  assign out_last  = last_q[S];
  assign out_max   = nd_val[1];
  assign out_idx   = nd_idx[1];

  // Accumulator update candidate: first beat always loads, later beats only on strict win.
  always_comb begin
    xfer     = out_valid & out_ready;
    take     = (beat_cnt == '0) |
               val_gt(CMP_MAX_W'(out_max), CMP_MAX_W'(acc.val), cmp_lsb(APPROX_LSB));
    acc_next = acc;
    if (take) begin
      acc_next.val  = out_max;
      acc_next.idx  = out_idx;
      acc_next.beat = beat_cnt;
    end
  end

  // Frame tracking; the closing beat publishes the result and restarts the frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc         <= '0;
      frame_res   <= '0;
      beat_cnt    <= '0;
      frame_valid <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      if (xfer) begin
        if (out_last) begin
          frame_res   <= acc_next;
          frame_valid <= 1'b1;
          acc         <= '0;
          beat_cnt    <= '0;
        end else begin
          acc <= acc_next;
          if (beat_cnt != '1) beat_cnt <= beat_cnt + CW'(1);
        end
      end
    end
  end

  assign frame_max  = frame_res.val;
  assign frame_idx  = frame_res.idx;
  assign frame_beat = frame_res.beat;

endmodule
